// File: rtl/idv_sweep_pkg.sv
// Shared types and helpers for the IDV ring-oscillator sweep controller.
// The oscillator count and index width are fixed by the bank macro.
package idv_sweep_pkg;

  localparam int NOSC  = 63;
  localparam int IDX_W = 6;
  localparam int CNT_W = 16;
  localparam int SET_W = 8;
  localparam int WIN_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAKE,
    ST_SETTLE,
    ST_MEASURE,
    ST_REPORT,
    ST_DONE
  } state_e;

  // Bit i of the result enables oscillator i; index 0 decodes to all-zero.
  function automatic logic [NOSC:1] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NOSC:1] oh;
    oh = '0;
    for (int i = 1; i <= NOSC; i++) begin
      oh[i] = (int'(idx) == i);
    end
    return oh;
  endfunction

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return (idx != '0) && (int'(idx) <= NOSC);
  endfunction

endpackage

// File: rtl/idv_edge_cnt.sv
// Synchronises the asynchronous bank output, detects rising edges and
// counts them in a saturating counter with clear, enable and overflow.
module idv_edge_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             async_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Once the counter is full, further edges only latch the overflow flag.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en_i && rise) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/idv_osc_sweep_ctrl.sv
// Sweeps the IDV oscillator bank: wake, enable one oscillator at a time,
// count bank-output edges over a window and hand each count to the host.
module idv_osc_sweep_ctrl #(
  parameter int CNT_W = idv_sweep_pkg::CNT_W,
  parameter int SET_W = idv_sweep_pkg::SET_W,
  parameter int WIN_W = idv_sweep_pkg::WIN_W
) (
  input  logic                            idvclk,
  input  logic                            idvrst_b,
  input  logic                            start,
  input  logic                            stop,
  input  logic [idv_sweep_pkg::IDX_W-1:0] cfg_first_idx,
  input  logic [idv_sweep_pkg::IDX_W-1:0] cfg_last_idx,
  input  logic [SET_W-1:0]                cfg_settle,
  input  logic [WIN_W-1:0]                cfg_window,
  input  logic                            hfbankl,
  output logic [idv_sweep_pkg::NOSC:1]    enosc,
  output logic                            sleep_b,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [idv_sweep_pkg::IDX_W-1:0] res_idx,
  output logic [CNT_W-1:0]                res_count,
  output logic                            res_ovf,
  output logic                            busy,
  output logic                            done,
  output logic                            cfg_err
);

  import idv_sweep_pkg::*;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [WIN_W-1:0] window_q, window_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [NOSC:1]    enosc_q, enosc_d;
  logic             sleep_b_q, sleep_b_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_ok;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt;
  logic             cnt_ovf;
  logic [SET_W-1:0] settle_load_cfg;
  logic [SET_W-1:0] settle_load_lat;

  assign cfg_ok = idx_in_range(cfg_first_idx) && idx_in_range(cfg_last_idx) &&
                  (cfg_first_idx <= cfg_last_idx) && (cfg_window != '0);

  // A settle of 0 still costs one cycle, the same as a settle of 1.
  assign settle_load_cfg = (cfg_settle == '0) ? '0 : cfg_settle - SET_W'(1);
  assign settle_load_lat = (settle_q == '0) ? '0 : settle_q - SET_W'(1);

  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    last_d    = last_q;
    settle_d  = settle_q;
    window_d  = window_q;
    set_cnt_d = set_cnt_q;
    win_cnt_d = win_cnt_q;
    cfg_err_d = 1'b0;
    cnt_clr   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          if (cfg_ok) begin
            state_d   = ST_WAKE;
            cur_idx_d = cfg_first_idx;
            last_d    = cfg_last_idx;
            settle_d  = cfg_settle;
            window_d  = cfg_window;
            set_cnt_d = settle_load_cfg;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_WAKE: begin
        if (set_cnt_q == '0) begin
          state_d   = ST_SETTLE;
          set_cnt_d = settle_load_lat;
        end else begin
          set_cnt_d = set_cnt_q - SET_W'(1);
        end
      end
      ST_SETTLE: begin
        if (set_cnt_q == '0) begin
          state_d   = ST_MEASURE;
          win_cnt_d = window_q - WIN_W'(1);
          cnt_clr   = 1'b1;
        end else begin
          set_cnt_d = set_cnt_q - SET_W'(1);
        end
      end
      ST_MEASURE: begin
        if (win_cnt_q == '0) begin
          state_d = ST_REPORT;
        end else begin
          win_cnt_d = win_cnt_q - WIN_W'(1);
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          if (cur_idx_q == last_q) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_SETTLE;
            cur_idx_d = cur_idx_q + IDX_W'(1);
            set_cnt_d = settle_load_lat;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (stop && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // Bank controls are registered from the next state so the macro sees
  // glitch-free levels and a direct one-hot hand-over between oscillators.
  always_comb begin
    enosc_d   = '0;
    sleep_b_d = 1'b0;
    if (state_d inside {ST_SETTLE, ST_MEASURE, ST_REPORT}) begin
      enosc_d = idx_onehot(cur_idx_d);
    end
    if (state_d inside {ST_WAKE, ST_SETTLE, ST_MEASURE, ST_REPORT}) begin
      sleep_b_d = 1'b1;
    end
  end

  always_ff @(posedge idvclk or negedge idvrst_b) begin
    if (!idvrst_b) begin
      state_q   <= ST_IDLE;
      cur_idx_q <= '0;
      last_q    <= '0;
      settle_q  <= '0;
      window_q  <= '0;
      set_cnt_q <= '0;
      win_cnt_q <= '0;
      enosc_q   <= '0;
      sleep_b_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      last_q    <= last_d;
      settle_q  <= settle_d;
      window_q  <= window_d;
      set_cnt_q <= set_cnt_d;
      win_cnt_q <= win_cnt_d;
      enosc_q   <= enosc_d;
      sleep_b_q <= sleep_b_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cnt_en = (state_q == ST_MEASURE);

  idv_edge_cnt #(
    .CNT_W(CNT_W)
  ) u_edge_cnt (
    .clk_i  (idvclk),
    .rst_n_i(idvrst_b),
    .async_i(hfbankl),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt),
    .ovf_o  (cnt_ovf)
  );

  // The counter is idle outside MEASURE, so its value is stable through REPORT.
  assign res_valid = (state_q == ST_REPORT);
  assign res_idx   = res_valid ? cur_idx_q : '0;
  assign res_count = res_valid ? cnt : '0;
  assign res_ovf   = res_valid & cnt_ovf;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign enosc     = enosc_q;
  assign sleep_b   = sleep_b_q;
  assign cfg_err   = cfg_err_q;

endmodule
